// File: rtl/fft_writer_pkg.sv
// Shared types and constants for the FFT result write-back path.
// Optional scaling is enabled with the FFT_WRITER_SCALE_EN macro.
package fft_writer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWrRe,
        StWrIm,
        StFinish
    } state_t;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTES_PER_WORD = 4;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pack_word.sv
// Packs samples 2*idx and 2*idx+1 of a flat vector into one memory word.
// With FFT_WRITER_SCALE_EN defined, each sample is first scaled by 1/FFT_N with rounding.
module fft_pack_word
    import fft_writer_pkg::*;
#(
    parameter int unsigned FFT_N  = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IDX_W  = 2
) (
    input  logic [FFT_N*DATA_W-1:0] vec,
    input  logic [IDX_W-1:0]        idx,
    output logic [WORD_W-1:0]       word
);

    logic [DATA_W-1:0] lo_raw;
    logic [DATA_W-1:0] hi_raw;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] hi;

`ifdef FFT_WRITER_SCALE_EN
    localparam int unsigned S = clog2(FFT_N);
    localparam logic [DATA_W:0] ROUND = (DATA_W+1)'(1) << (S - 1);

    // One extra bit of headroom keeps the rounding add from wrapping.
    function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] x);
        logic signed [DATA_W:0] ext;
        ext = $signed({x[DATA_W-1], x} + ROUND);
        ext = ext >>> S;
        return ext[DATA_W-1:0];
    endfunction
`endif

    always_comb begin
        lo_raw = vec[(2 * int'(idx)) * DATA_W +: DATA_W];
        hi_raw = vec[(2 * int'(idx) + 1) * DATA_W +: DATA_W];
`ifdef FFT_WRITER_SCALE_EN
        lo = scale(lo_raw);
        hi = scale(hi_raw);
`else
        lo = lo_raw;
        hi = hi_raw;
`endif
        word = WORD_W'({hi, lo});
    end

endmodule

// File: rtl/fft_result_writer.sv
// Drains the FFT core's real/imag outputs into data memory as packed words.
// Optional 1/FFT_N output scaling is selected by the FFT_WRITER_SCALE_EN macro.
module fft_result_writer
    import fft_writer_pkg::*;
#(
    parameter int unsigned FFT_N  = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       re_base_addr,
    input  logic [ADDR_W-1:0]       im_base_addr,
    input  logic [FFT_N*DATA_W-1:0] fft_out_re_flat,
    input  logic [FFT_N*DATA_W-1:0] fft_out_im_flat,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [WORD_W-1:0]       mem_wdata,
    input  logic                    mem_ready,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned W  = FFT_N / 2;
    localparam int unsigned KW = (W > 1) ? clog2(W) : 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES_PER_WORD - 1);

    state_t                  state_q;
    logic [KW-1:0]           k_q;
    logic [FFT_N*DATA_W-1:0] re_snap;
    logic [FFT_N*DATA_W-1:0] im_snap;
    logic [ADDR_W-1:0]       re_base_q;
    logic [ADDR_W-1:0]       im_base_q;
    logic                    last;
    logic [FFT_N*DATA_W-1:0] pack_vec;
    logic [KW-1:0]           pack_idx;
    logic [WORD_W-1:0]       pack_out;

    assign last = (k_q == KW'(W - 1));

    // The packer prepares the word for the *next* cycle so mem_wdata stays registered.
    always_comb begin
        pack_vec = re_snap;
        pack_idx = k_q + 1'b1;
        unique case (state_q)
            StIdle: begin
                pack_vec = fft_out_re_flat;
                pack_idx = '0;
            end
            StWrRe: begin
                if (last) begin
                    pack_vec = im_snap;
                    pack_idx = '0;
                end
            end
            StWrIm:   pack_vec = im_snap;
            default: ;
        endcase
    end

    fft_pack_word #(
        .FFT_N  (FFT_N),
        .DATA_W (DATA_W),
        .IDX_W  (KW)
    ) u_pack (
        .vec  (pack_vec),
        .idx  (pack_idx),
        .word (pack_out)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            k_q       <= '0;
            re_snap   <= '0;
            im_snap   <= '0;
            re_base_q <= '0;
            im_base_q <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        re_snap   <= fft_out_re_flat;
                        im_snap   <= fft_out_im_flat;
                        re_base_q <= re_base_addr & ALIGN_MASK;
                        im_base_q <= im_base_addr & ALIGN_MASK;
                        k_q       <= '0;
                        mem_we    <= 1'b1;
                        mem_addr  <= re_base_addr & ALIGN_MASK;
                        mem_wdata <= pack_out;
                        busy      <= 1'b1;
                        state_q   <= StWrRe;
                    end
                end
                StWrRe: begin
                    if (mem_ready) begin
                        mem_wdata <= pack_out;
                        if (last) begin
                            k_q      <= '0;
                            mem_addr <= im_base_q;
                            state_q  <= StWrIm;
                        end else begin
                            k_q      <= k_q + 1'b1;
                            mem_addr <= mem_addr + ADDR_W'(BYTES_PER_WORD);
                        end
                    end
                end
                StWrIm: begin
                    if (mem_ready) begin
                        if (last) begin
                            k_q     <= '0;
                            mem_we  <= 1'b0;
                            done    <= 1'b1;
                            state_q <= StFinish;
                        end else begin
                            k_q       <= k_q + 1'b1;
                            mem_addr  <= mem_addr + ADDR_W'(BYTES_PER_WORD);
                            mem_wdata <= pack_out;
                        end
                    end
                end
                StFinish: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_result_writer.sv
// Scoreboard bench for fft_result_writer; honours FFT_WRITER_SCALE_EN when defined.
module tb_fft_result_writer;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          mem_ready = 1'b0;
    logic [AW-1:0] re_base_addr = '0;
    logic [AW-1:0] im_base_addr = '0;
    logic [N*DW-1:0] re_v = '0;
    logic [N*DW-1:0] im_v = '0;
    logic          mem_we;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;

    int checks = 0;
    int failures = 0;
    int accepted = 0;
    logic [63:0] sb[$];
    logic [31:0] acc_data[$];
    logic [63:0] mon_exp;

    always #5 clk = ~clk;

    fft_result_writer #(
        .FFT_N  (N),
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .re_base_addr    (re_base_addr),
        .im_base_addr    (im_base_addr),
        .fft_out_re_flat (re_v),
        .fft_out_im_flat (im_v),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ready       (mem_ready),
        .busy            (busy),
        .done            (done)
    );

    // Reference sample transform: floor division of (x + N/2) by N when scaling.
    function automatic logic [15:0] model_sample(input logic [N*DW-1:0] v, input int i);
        logic signed [15:0] x;
        int xv;
        int q;
        x = v[i*DW +: DW];
`ifdef FFT_WRITER_SCALE_EN
        xv = int'(x) + N / 2;
        if (xv >= 0) q = xv / N;
        else q = -((-xv + N - 1) / N);
        return q[15:0];
`else
        xv = int'(x);
        q = xv;
        return q[15:0];
`endif
    endfunction

    task automatic push_expected(input logic [31:0] rb, input logic [31:0] ib);
        logic [31:0] a;
        for (int k = 0; k < N / 2; k++) begin
            a = (rb & 32'hFFFF_FFFC) + 32'(4 * k);
            sb.push_back({a, model_sample(re_v, 2*k+1), model_sample(re_v, 2*k)});
        end
        for (int k = 0; k < N / 2; k++) begin
            a = (ib & 32'hFFFF_FFFC) + 32'(4 * k);
            sb.push_back({a, model_sample(im_v, 2*k+1), model_sample(im_v, 2*k)});
        end
    endtask

    // Leaves the caller 1 time unit into cycle 1 (start sampled at edge 0).
    task automatic kick(input logic [31:0] rb, input logic [31:0] ib);
        @(posedge clk); #1;
        re_base_addr = rb;
        im_base_addr = ib;
        start = 1'b1;
        push_expected(rb, ib);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic set_basic();
        for (int i = 0; i < N; i++) begin
            re_v[i*DW +: DW] = DW'(i * 256);
            im_v[i*DW +: DW] = DW'(-i);
        end
    endtask

    // Scoreboard: every accepted write must match the oldest expected word.
    always @(negedge clk) begin
        if (reset && mem_we && mem_ready) begin
            accepted++;
            acc_data.push_back(mem_wdata);
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_write addr=%h data=%h", mem_addr, mem_wdata);
            end else begin
                mon_exp = sb.pop_front();
                if ({mem_addr, mem_wdata} !== mon_exp) begin
                    failures++;
                    $display("FAIL sb_write got addr=%h data=%h expected addr=%h data=%h",
                             mem_addr, mem_wdata, mon_exp[63:32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", mem_we); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (mem_addr !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== '0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int n;
        int done_cyc;
        bit busy_ok;
        set_basic();
        accepted = 0; busy_ok = 1; done_cyc = 0; n = 1;
        mem_ready = 1'b1;
        kick(32'h1000, 32'h2000);
        while (done_cyc == 0 && n <= 40) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 0;
            if (done === 1'b1) done_cyc = n;
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk);
        checks++; if (done_cyc != 9) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=9", done_cyc); end
        checks++; if (!busy_ok) begin failures++; $display("FAIL basic_busy_window got=low exp=high"); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
        checks++; if (accepted != 8) begin failures++; $display("FAIL basic_count got=%0d exp=8", accepted); end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL basic_sb_left got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_backpressure();
        int n;
        int done_cyc;
        logic [31:0] exp_w;
        set_basic();
        exp_w = {model_sample(re_v, 3), model_sample(re_v, 2)};
        accepted = 0; done_cyc = 0; n = 1;
        kick(32'h1000, 32'h2000);
        while (done_cyc == 0 && n <= 40) begin
            mem_ready = !(n >= 2 && n <= 4);
            @(negedge clk);
            if (n >= 2 && n <= 5) begin
                checks++;
                if (mem_we !== 1'b1 || mem_addr !== 32'h1004 || mem_wdata !== exp_w) begin
                    failures++;
                    $display("FAIL bp_hold cyc=%0d got we=%b addr=%h data=%h exp we=1 addr=1004 data=%h",
                             n, mem_we, mem_addr, mem_wdata, exp_w);
                end
            end
            if (done === 1'b1) done_cyc = n;
            @(posedge clk); #1;
            n++;
        end
        mem_ready = 1'b1;
        checks++; if (done_cyc != 12) begin failures++; $display("FAIL bp_done_cycle got=%0d exp=12", done_cyc); end
        checks++; if (accepted != 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", accepted); end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL bp_sb_left got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_start_while_busy();
        int done_cnt;
        int done_cyc;
        set_basic();
        accepted = 0; done_cnt = 0; done_cyc = 0;
        mem_ready = 1'b1;
        kick(32'h1000, 32'h2000);
        for (int n = 1; n <= 20; n++) begin
            if (n == 2) begin re_v = '0; im_v = '0; end
            if (n == 3) start = 1'b1;
            if (n == 4) start = 1'b0;
            @(negedge clk);
            if (done === 1'b1) begin done_cnt++; done_cyc = n; end
            @(posedge clk); #1;
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL busy_done_count got=%0d exp=1", done_cnt); end
        checks++; if (done_cyc != 9) begin failures++; $display("FAIL busy_done_cycle got=%0d exp=9", done_cyc); end
        checks++; if (accepted != 8) begin failures++; $display("FAIL busy_count got=%0d exp=8", accepted); end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL busy_sb_left got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_reset_midop();
        int done_cnt;
        int done_cyc;
        int n;
        set_basic();
        accepted = 0; done_cnt = 0;
        mem_ready = 1'b1;
        kick(32'h1000, 32'h2000);
        for (n = 1; n <= 12; n++) begin
            if (n == 4) begin reset = 1'b0; mem_ready = 1'b0; end
            if (n == 6) begin reset = 1'b1; mem_ready = 1'b1; end
            @(negedge clk);
            if (n == 5) begin
                checks++;
                if (mem_we !== 1'b0 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL abort_outputs got we=%b busy=%b exp we=0 busy=0", mem_we, busy);
                end
            end
            if (done === 1'b1) done_cnt++;
            @(posedge clk); #1;
        end
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", done_cnt); end
        checks++; if (accepted != 3) begin failures++; $display("FAIL abort_count got=%0d exp=3", accepted); end
        checks++; if (sb.size() != 5) begin failures++; $display("FAIL abort_sb_left got=%0d exp=5", sb.size()); end
        sb.delete();
        accepted = 0; done_cyc = 0; n = 1;
        kick(32'h1000, 32'h2000);
        while (done_cyc == 0 && n <= 40) begin
            @(negedge clk);
            if (done === 1'b1) done_cyc = n;
            @(posedge clk); #1;
            n++;
        end
        checks++; if (done_cyc != 9) begin failures++; $display("FAIL restart_done_cycle got=%0d exp=9", done_cyc); end
        checks++; if (accepted != 8) begin failures++; $display("FAIL restart_count got=%0d exp=8", accepted); end
    endtask

    task automatic test_alignment();
        int n;
        int done_cyc;
        set_basic();
        accepted = 0; done_cyc = 0; n = 1;
        mem_ready = 1'b1;
        kick(32'h1002, 32'h2003);
        while (done_cyc == 0 && n <= 40) begin
            @(negedge clk);
            if (done === 1'b1) done_cyc = n;
            @(posedge clk); #1;
            n++;
        end
        checks++; if (accepted != 8) begin failures++; $display("FAIL align_count got=%0d exp=8", accepted); end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL align_sb_left got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_scale();
        int n;
        int done_cyc;
        logic [31:0] exp0;
        logic [31:0] exp1;
        re_v = '0; im_v = '0;
        re_v[0*DW +: DW] = 16'h7FFF;
        re_v[1*DW +: DW] = 16'hFFF8;
        re_v[2*DW +: DW] = 16'h8000;
        re_v[3*DW +: DW] = 16'h0003;
`ifdef FFT_WRITER_SCALE_EN
        exp0 = 32'hFFFF_1000;
        exp1 = 32'h0000_F000;
`else
        exp0 = 32'hFFF8_7FFF;
        exp1 = 32'h0003_8000;
`endif
        acc_data.delete();
        accepted = 0; done_cyc = 0; n = 1;
        mem_ready = 1'b1;
        kick(32'h1000, 32'h2000);
        while (done_cyc == 0 && n <= 40) begin
            @(negedge clk);
            if (done === 1'b1) done_cyc = n;
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (acc_data.size() < 2) begin
            failures++;
            $display("FAIL scale_words got=%0d exp>=2", acc_data.size());
        end else begin
            if (acc_data[0] !== exp0) begin failures++; $display("FAIL scale_word0 got=%h exp=%h", acc_data[0], exp0); end
            checks++;
            if (acc_data[1] !== exp1) begin failures++; $display("FAIL scale_word1 got=%h exp=%h", acc_data[1], exp1); end
        end
        checks++; if (done_cyc != 9) begin failures++; $display("FAIL scale_done_cycle got=%0d exp=9", done_cyc); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_start_while_busy();
        test_reset_midop();
        test_alignment();
        test_scale();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_result_writer.md
Name: fft_result_writer

Overview:
- Write-back end of the FFT accelerator path: drains the FFT core's flat real/imag output vectors into data memory as packed 32-bit words.
- Uses the same layout the loader consumes: word k = {sample[2k+1], sample[2k]}, real block at RE base, imag block at IM base.
- Sits between the FFT core and the data-memory write port inside the CPU's FFT interface.
- Kicked off once per FFT instruction after the core signals its result is valid.

Parameters:
- FFT_N, 8, number of complex samples; even, >= 2.
- DATA_W, 16, sample width (Q1.15).
- ADDR_W, 32, byte-address width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to write back the current FFT result.
- re_base_addr  input  ADDR_W  byte address of the real block (from rs1).
- im_base_addr  input  ADDR_W  byte address of the imag block (from rs2).
- fft_out_re_flat  input  FFT_N*DATA_W  real outputs; sample i at [i*DATA_W +: DATA_W].
- fft_out_im_flat  input  FFT_N*DATA_W  imag outputs, same packing.
- mem_we  output  1  write request to data memory.
- mem_addr  output  ADDR_W  byte address of the write.
- mem_wdata  output  32  packed write word.
- mem_ready  input  1  memory accepts the write this cycle when mem_we && mem_ready.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the last word has been accepted.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; mem_we, busy, done, mem_addr, mem_wdata, word counter all 0.
- Derived: W = FFT_N/2 words per block.
- States: IDLE, WR_RE, WR_IM, FINISH.
- IDLE: on start, snapshot both flat vectors and both base addresses, with base[1:0] forced to 0 (word-aligned). Clear counter k; go to WR_RE. Later changes on the inputs do not affect the written data.
- WR_RE:
  - mem_we=1, mem_addr=re_base+4k, mem_wdata={re[2k+1], re[2k]}.
  - On mem_ready: k++. If k==W-1, clear k and go to WR_IM.
  - Without mem_ready: addr, data and we are held stable.
- WR_IM: identical, using im_base and the imag snapshot; after the last accepted word go to FINISH.
- FINISH: mem_we=0, done=1 for one cycle, busy=0 next cycle, return to IDLE.
- busy=1 in WR_RE, WR_IM and FINISH.
- start while not in IDLE is ignored (no queueing).
- Latency with mem_ready tied high: start sampled at edge 0; writes occur on cycles 1..2W; done on cycle 2W+1. For FFT_N=8, done is on cycle 9.
- Each stall cycle (mem_ready low) adds exactly one cycle. Words are never skipped or duplicated.
- Address arithmetic wraps modulo 2^ADDR_W; no error flag.
- Reset mid-operation: abort immediately. No further writes, no done pulse, snapshot discarded.

Optional Feature:
- Macro: FFT_WRITER_SCALE_EN.
- Defined: every sample is scaled by 1/FFT_N before packing: y = (x + 2^(S-1)) >>> S, with S = log2(FFT_N). Computed at DATA_W+1 bits, then truncated to DATA_W; cannot overflow. Adds no latency. FFT_N must be a power of two.
- Undefined: samples are packed unmodified.

Decomposition:
- Package fft_writer_pkg:
  - state encoding (IDLE, WR_RE, WR_IM, FINISH);
  - WORD_W=32, BYTES_PER_WORD=4;
  - function clog2 for S.
- Sub-module fft_pack_word: combinational.
  - Inputs: flat vector snapshot and word index.
  - Output: the packed 32-bit word.
  - Contains the optional scaling logic.
  - Instantiated once and muxed between the real and imag snapshots.

Test Plan:
- Basic: FFT_N=8, re[i]=i*256, im[i]=-i, bases 1000/2000, mem_ready=1.
  - Expect writes 1000:0x01000000, 1004:0x03000200, 1008:0x05000400, 100C:0x07000600.
  - Then 2000:0xFFFF0000, 2004:0xFFFDFFFE, 2008:0xFFFBFFFC, 200C:0xFFF9FFFA.
  - done on cycle 9, busy high on cycles 1-9.
- Backpressure: same stimulus, mem_ready=0 for 3 cycles during the second write.
  - Expect addr 1004 and data 0x03000200 held stable, exactly 8 accepted writes, done on cycle 12.
- Start while busy, and inputs changed after start:
  - Pulse start again at cycle 3 and zero the flat inputs at cycle 2.
  - Expect the original data written and only one done pulse.
- Reset mid-op: drive reset low after the 3rd accepted write.
  - Next cycle: mem_we=0, busy=0, no done.
  - A fresh start rewrites from 1000 at k=0.
- Alignment: re_base=1002, im_base=2003.
  - Expect writes starting at 1000 and 2000.
- FFT_WRITER_SCALE_EN, FFT_N=8: re[0]=0x7FFF, re[1]=0xFFF8, re[2]=0x8000, re[3]=0x0003.
  - Expect word 0 = 0xFFFF1000 and word 1 = 0x0000F000.
